mcycle_cpu: RTL and testbench
=============================

# mcycle_cpu

Parametrised multi-cycle CPU core: the next-generation replacement for the fixed 4-bit control unit / ALU / register file / PC / flag-register set. It fetches instructions from an external instruction memory over a req/ack handshake and executes each one through a fetch–decode–execute–writeback state machine. It provides a parametrised data width, register count and PC width, SUB, load-immediate, three conditional jumps and HALT.

## Interface
- DATA_W, 8, datapath/register width (≥4)
- REG_AW, 3, register address bits; 2**REG_AW registers
- PC_W, 8, program counter width (≤ DATA_W)
- INSTR_W, 4+2*REG_AW+DATA_W (derived, 18 at defaults), instruction width
- clock  in  1  rising-edge clock; the single clock domain
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  instruction valid this cycle
- imem_rdata  in  INSTR_W  instruction word
- pc  out  PC_W  current program counter
- flags  out  3  {CF, ZF, SF}
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  core stopped on HALT

## Operation
- Instruction fields: [INSTR_W-1 -: 4] opcode, then rd, then rs1 (REG_AW bits each), then imm[DATA_W-1:0]. rs2 = imm[REG_AW-1:0].
- 0000 ADD, 0001 AND, 0010 SHR, 0011 SUB: rd = rs1 op rs2.
- 0100–0111: the same four operations with B = imm.
- 1100 LDI: rd = imm. Flags unchanged.
- 1000 JMP: pc = imm[PC_W-1:0].
- 1001 JZ, 1010 JC, 1011 JS: jump if ZF / CF / SF is set; otherwise pc+1.
- 1111 HALT. All other opcodes are NOP (pc+1, retire pulses).
- ALU results and flag rules:
  - ADD: {CF,R} = A+B.
  - SUB: R = A−B; CF = 1 on borrow (A<B).
  - AND: CF = 0.
  - SHR: logical right shift; a shift amount ≥ DATA_W gives R = 0; CF = 0.
  - ZF = (R==0); SF = R[DATA_W-1].
- Flags update only on ALU opcodes (0000–0111). Jumps use the flag values held before the jump.
- PC arithmetic is modulo 2**PC_W: pc+1 wraps from all-ones to 0.
- Register 0 is an ordinary writable register.
- FSM states: FETCH, DECODE, EXEC, WB, HALT.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_rdata and go to DECODE. Otherwise stay in FETCH.
  - DECODE: read rs1 and rs2 into operand registers.
  - EXEC: compute the ALU result, the flags and next_pc.
  - WB: write rd (ALU/LDI only), pc <= next_pc, retire=1, go to FETCH. HALT opcode goes to HALT instead; retire still pulses.
  - HALT: terminal. halted=1, imem_req=0. Only reset exits.

## Timing
- Reset values: state=FETCH, pc=0, flags=000, all registers 0, retire=0, halted=0. imem_req=1 in the first cycle after reset is released.
- Latency: 4 cycles per instruction when imem_ack arrives in the same cycle as imem_req. Each cycle of ack delay adds one cycle.
- imem_req holds high in FETCH until ack. imem_addr is stable throughout FETCH.
- imem_ack outside FETCH is ignored.
- Reset asserted mid-operation (any state): next cycle is FETCH at pc=0. No register write, no retire, and any ack in the reset cycle is ignored.
- A write to rd in WB is visible to the following instruction's DECODE, because the register file is written at the WB edge.

## Structure
- Package mcycle_cpu_pkg: opcode constants, FSM state encoding, and field-offset functions of REG_AW/DATA_W.
- Sub-module cpu_alu (parametrised DATA_W): combinational; takes A, B and op[1:0]; returns R, CF, ZF, SF.
- Register file, PC, flag register and FSM live in mcycle_cpu.

## Test plan
- Reset, then the program LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT, with ack in the same cycle → r3=8, flags=000. Four retire pulses spaced 4 cycles apart, then halted=1 and imem_req=0.
- SUB r3 = 3−5 → R=0xFE, CF=1, SF=1, ZF=0. SUB 5−5 → R=0, ZF=1, CF=0.
- SHRI with imm=8 on r=0xFF → R=0, ZF=1. SHRI with imm=1 → 0x7F.
- After a result of 0, JZ 0x40 → pc=0x40. After a nonzero result, JZ → pc+1. At pc=0xFF, a NOP → pc=0x00.
- Ack delayed 3 cycles → imem_req and imem_addr stay stable for 4 cycles; a spurious ack during EXEC has no effect.
- Reset asserted during EXEC of ADD r3 → r3 is unchanged, no retire pulse, pc=0 and imem_req=1 the next cycle.

Source files
------------

// File: rtl/mcycle_cpu_pkg.sv
// Shared constants for the multi-cycle core: opcodes, ALU op select,
// FSM state encoding and instruction field positions.
package mcycle_cpu_pkg;

  // Control-flow and special opcodes (0000-0111 are ALU operations)
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JZ   = 4'b1001;
  localparam logic [3:0] OP_JC   = 4'b1010;
  localparam logic [3:0] OP_JS   = 4'b1011;
  localparam logic [3:0] OP_LDI  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU operation select, taken from opcode[1:0]
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_SHR = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  // FSM state encoding
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  // Instruction layout: {opcode[3:0], rd, rs1, imm[DATA_W-1:0]}
  function automatic int instr_width(input int reg_aw, input int data_w);
    return 4 + 2 * reg_aw + data_w;
  endfunction

  function automatic int rd_msb(input int reg_aw, input int data_w);
    return 2 * reg_aw + data_w - 1;
  endfunction

  function automatic int rs1_msb(input int reg_aw, input int data_w);
    return reg_aw + data_w - 1;
  endfunction

  // Opcodes 0000-0111 are the ALU class (register or immediate B operand)
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: ADD, AND, logical SHR and SUB with carry/zero/sign flags.
module cpu_alu
  import mcycle_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] r_o,
  output logic              cf_o,
  output logic              zf_o,
  output logic              sf_o
);

  localparam logic [DATA_W-1:0] DW_L = DATA_W'(DATA_W);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  // The extra top bit of the widened difference is the borrow (set when A < B)
  assign diff_s = {1'b0, a_i} - {1'b0, b_i};

  // Select the result and carry for the requested operation
  always_comb begin
    r_o  = {DATA_W{1'b0}};
    cf_o = 1'b0;
    case (op_i)
      ALU_ADD: begin
        r_o  = sum_s[DATA_W-1:0];
        cf_o = sum_s[DATA_W];
      end
      ALU_AND: begin
        r_o  = a_i & b_i;
        cf_o = 1'b0;
      end
      ALU_SHR: begin
        cf_o = 1'b0;
        if (b_i >= DW_L) begin
          r_o = {DATA_W{1'b0}};
        end else begin
          r_o = a_i >> b_i;
        end
      end
      ALU_SUB: begin
        r_o  = diff_s[DATA_W-1:0];
        cf_o = diff_s[DATA_W];
      end
      default: begin
        r_o  = {DATA_W{1'b0}};
        cf_o = 1'b0;
      end
    endcase
  end

  assign zf_o = (r_o == {DATA_W{1'b0}});
  assign sf_o = r_o[DATA_W-1];

endmodule

// File: rtl/mcycle_cpu.sv
// Multi-cycle CPU core: FETCH -> DECODE -> EXEC -> WB per instruction,
// with register file, program counter, flag register and control FSM.
module mcycle_cpu
  import mcycle_cpu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_AW  = 3,
  parameter  int PC_W    = 8,
  localparam int INSTR_W = instr_width(REG_AW, DATA_W)
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         flags,
  output logic               retire,
  output logic               halted
);

  localparam int RD_MSB  = rd_msb(REG_AW, DATA_W);
  localparam int RS1_MSB = rs1_msb(REG_AW, DATA_W);
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0]  opa_q, opb_q, res_q;
  logic [2:0]         alu_flags_q;
  logic [PC_W-1:0]    pc_q, next_pc_q, next_pc_d, pc_inc_s;
  logic [2:0]         flags_q;
  logic               retire_q, halted_q, req_q;
  logic [DATA_W-1:0]  rf_q [2**REG_AW];

  logic [3:0]         opcode_s;
  logic [REG_AW-1:0]  rd_s, rs1_s, rs2_s;
  logic [DATA_W-1:0]  imm_s, alu_b_s, alu_r_s;
  logic               alu_cf_s, alu_zf_s, alu_sf_s;

  assign opcode_s = ir_q[INSTR_W-1 -: 4];
  assign rd_s     = ir_q[RD_MSB -: REG_AW];
  assign rs1_s    = ir_q[RS1_MSB -: REG_AW];
  assign imm_s    = ir_q[DATA_W-1:0];
  assign rs2_s    = imm_s[REG_AW-1:0];
  // Opcodes x1xx take the immediate as the B operand
  assign alu_b_s  = opcode_s[2] ? imm_s : opb_q;
  assign pc_inc_s = pc_q + PC_ONE;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i  (opa_q),
    .b_i  (alu_b_s),
    .op_i (opcode_s[1:0]),
    .r_o  (alu_r_s),
    .cf_o (alu_cf_s),
    .zf_o (alu_zf_s),
    .sf_o (alu_sf_s)
  );

  // Next PC: jumps test the flags held before this instruction
  always_comb begin
    next_pc_d = pc_inc_s;
    case (opcode_s)
      OP_JMP: next_pc_d = imm_s[PC_W-1:0];
      OP_JZ: begin
        if (flags_q[1]) next_pc_d = imm_s[PC_W-1:0];
        else            next_pc_d = pc_inc_s;
      end
      OP_JC: begin
        if (flags_q[2]) next_pc_d = imm_s[PC_W-1:0];
        else            next_pc_d = pc_inc_s;
      end
      OP_JS: begin
        if (flags_q[0]) next_pc_d = imm_s[PC_W-1:0];
        else            next_pc_d = pc_inc_s;
      end
      OP_HALT: next_pc_d = pc_q;
      default: next_pc_d = pc_inc_s;
    endcase
  end

  // FSM next state; acks are only honoured while fetching
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) state_d = ST_DECODE;
        else          state_d = ST_FETCH;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        if (opcode_s == OP_HALT) state_d = ST_HALT;
        else                     state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Control and datapath registers; outputs are registered from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      ir_q        <= {INSTR_W{1'b0}};
      opa_q       <= {DATA_W{1'b0}};
      opb_q       <= {DATA_W{1'b0}};
      res_q       <= {DATA_W{1'b0}};
      alu_flags_q <= 3'b000;
      next_pc_q   <= {PC_W{1'b0}};
      pc_q        <= {PC_W{1'b0}};
      flags_q     <= 3'b000;
      retire_q    <= 1'b0;
      halted_q    <= 1'b0;
      req_q       <= 1'b1;
    end else begin
      state_q  <= state_d;
      retire_q <= (state_d == ST_WB);
      halted_q <= (state_d == ST_HALT);
      req_q    <= (state_d == ST_FETCH);
      if ((state_q == ST_FETCH) && imem_ack) begin
        ir_q <= imem_rdata;
      end
      if (state_q == ST_DECODE) begin
        opa_q <= rf_q[rs1_s];
        opb_q <= rf_q[rs2_s];
      end
      if (state_q == ST_EXEC) begin
        res_q       <= alu_r_s;
        alu_flags_q <= {alu_cf_s, alu_zf_s, alu_sf_s};
        next_pc_q   <= next_pc_d;
      end
      if (state_q == ST_WB) begin
        pc_q <= next_pc_q;
        if (is_alu_op(opcode_s)) begin
          flags_q <= alu_flags_q;
        end
      end
    end
  end

  // Register file: written at the WB edge so the next DECODE sees the value
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_AW; i++) begin
        rf_q[i] <= {DATA_W{1'b0}};
      end
    end else if (state_q == ST_WB) begin
      if (is_alu_op(opcode_s)) begin
        rf_q[rd_s] <= res_q;
      end else if (opcode_s == OP_LDI) begin
        rf_q[rd_s] <= imm_s;
      end
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flags     = flags_q;
  assign retire    = retire_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mcycle_cpu.sv
// Self-checking bench for mcycle_cpu: instruction-level reference model with
// per-cycle output comparison, directed programs and randomized programs.
module tb_mcycle_cpu;

  localparam int DATA_W  = 8;
  localparam int REG_AW  = 3;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 18;

  logic               clock, reset, imem_req, imem_ack, retire, halted;
  logic [PC_W-1:0]    imem_addr, pc;
  logic [INSTR_W-1:0] imem_rdata;
  logic [2:0]         flags;

  mcycle_cpu #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .flags(flags),
    .retire(retire), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [INSTR_W-1:0] mem [256];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  m_pc;
  logic [2:0]  m_flags;
  logic [7:0]  m_regs [8];
  logic        m_halted;
  int          m_wait;    // 0 fetching, 1..3 = cycles since the fetch was accepted
  logic [17:0] m_ir;
  bit          m_valid = 1'b0;

  // Memory responder state
  int ack_fix = 0;
  bit spur_en = 1'b0;
  int wait_cnt = 0;
  int cur_delay = 0;
  int cyc = 0;
  int ret_cyc[$];

  function automatic logic [17:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [7:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural effect of one instruction
  task automatic model_exec();
    logic [3:0] op;
    logic [2:0] rd, rs1;
    logic [7:0] imm;
    int a, b, r;
    bit cf;
    op = m_ir[17:14]; rd = m_ir[13:11]; rs1 = m_ir[10:8]; imm = m_ir[7:0];
    a = int'(m_regs[rs1]);
    b = op[2] ? int'(imm) : int'(m_regs[imm[2:0]]);
    if (op < 4'd8) begin
      case (op[1:0])
        2'd0: begin r = a + b; cf = (r > 255); r = r % 256; end
        2'd1: begin r = a & b; cf = 1'b0; end
        2'd2: begin r = (b >= 8) ? 0 : (a >> b); cf = 1'b0; end
        default: begin cf = (a < b); r = (a - b + 256) % 256; end
      endcase
      m_regs[rd] = 8'(r);
      m_flags = {cf, (r == 0), (r >= 128)};
      m_pc = m_pc + 8'd1;
    end else begin
      case (op)
        4'd8:  m_pc = imm;
        4'd9:  m_pc = m_flags[1] ? imm : m_pc + 8'd1;
        4'd10: m_pc = m_flags[2] ? imm : m_pc + 8'd1;
        4'd11: m_pc = m_flags[0] ? imm : m_pc + 8'd1;
        4'd12: begin m_regs[rd] = imm; m_pc = m_pc + 8'd1; end
        4'd15: m_halted = 1'b1;
        default: m_pc = m_pc + 8'd1;
      endcase
    end
  endtask

  // Advance the model across the rising edge that just happened
  task automatic model_step();
    if (reset) begin
      m_pc = 8'd0; m_flags = 3'd0; m_halted = 1'b0; m_wait = 0; m_valid = 1'b1;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
    end else if (m_valid && !m_halted) begin
      if (m_wait == 0) begin
        if (imem_ack) begin m_ir = mem[m_pc]; m_wait = 1; end
      end else if (m_wait < 3) begin
        m_wait++;
      end else begin
        model_exec();
        m_wait = 0;
      end
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = !m_halted && (m_wait == 0);
    check("imem_req", int'(imem_req), int'(exp_req));
    if (exp_req) check("imem_addr", int'(imem_addr), int'(m_pc));
    if (!m_halted) check("pc", int'(pc), int'(m_pc));
    check("flags", int'(flags), int'(m_flags));
    check("retire", int'(retire), int'(!m_halted && (m_wait == 3)));
    check("halted", int'(halted), int'(m_halted));
    if (m_wait == 0)
      for (int i = 0; i < 8; i++)
        check($sformatf("reg%0d", i), int'(dut.rf_q[i]), int'(m_regs[i]));
  endtask

  function automatic int pick_delay();
    return (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
  endfunction

  task automatic drive(input bit rst_v);
    reset = rst_v;
    if (imem_req) begin
      if (wait_cnt >= cur_delay) begin
        imem_ack = 1'b1; imem_rdata = mem[imem_addr]; wait_cnt = 0; cur_delay = pick_delay();
      end else begin
        imem_ack = 1'b0; imem_rdata = 18'($urandom); wait_cnt++;
      end
    end else begin
      imem_ack = spur_en && ($urandom_range(0, 2) == 0);
      imem_rdata = 18'($urandom); wait_cnt = 0;
    end
  endtask

  task automatic tick(input bit rst_v);
    @(negedge clock);
    cyc++;
    model_step();
    if (m_valid) compare();
    if (retire) ret_cyc.push_back(cyc);
    drive(rst_v);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = enc(4'hD, 3'd0, 3'd0, 8'd0);
  endtask

  task automatic start_prog(input int fix, input bit spur);
    ack_fix = fix; spur_en = spur; wait_cnt = 0; cur_delay = pick_delay();
    tick(1'b1); tick(1'b1);
    ret_cyc.delete();
  endtask

  task automatic run_to_halt(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick(1'b0);
      if (halted) done = 1'b1;
    end
    check({name, "_halt_reached"}, int'(done), 1);
    tick(1'b0); tick(1'b0);
  endtask

  task automatic check_gaps(input string name, input int count, input int gap);
    check({name, "_retire_count"}, ret_cyc.size(), count);
    for (int i = 1; i < ret_cyc.size(); i++)
      check({name, "_retire_gap"}, ret_cyc[i] - ret_cyc[i-1], gap);
  endtask

  initial begin
    bit found;
    logic [17:0] w;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 18'd0;

    // A: LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT with zero-latency ack
    clear_mem();
    mem[0] = enc(4'hC, 3'd1, 3'd0, 8'd5);
    mem[1] = enc(4'hC, 3'd2, 3'd0, 8'd3);
    mem[2] = enc(4'h0, 3'd3, 3'd1, 8'd2);
    mem[3] = enc(4'hF, 3'd0, 3'd0, 8'd0);
    start_prog(0, 1'b0);
    check("A_reset_req", int'(imem_req), 1);
    check("A_reset_pc", int'(pc), 0);
    run_to_halt("A", 60);
    check("A_r3", int'(dut.rf_q[3]), 8);
    check("A_model_r3", int'(m_regs[3]), 8);
    check("A_flags", int'(flags), 0);
    check("A_halted", int'(halted), 1);
    check("A_req_off", int'(imem_req), 0);
    check_gaps("A", 4, 4);

    // Reset during EXEC of the ADD: no write, no retire, restart at pc 0
    start_prog(0, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick(1'b0);
      if (m_wait == 2 && m_pc == 8'd2) found = 1'b1;
    end
    check("R_exec_reached", int'(found), 1);
    reset = 1'b1; imem_ack = 1'b1;
    tick(1'b0);
    check("R_retire", int'(retire), 0);
    check("R_req", int'(imem_req), 1);
    check("R_pc", int'(pc), 0);
    check("R_r3", int'(dut.rf_q[3]), 0);

    // B: SUB 3-5 with ack delayed 3 cycles and spurious acks
    clear_mem();
    mem[0] = enc(4'hC, 3'd1, 3'd0, 8'd3);
    mem[1] = enc(4'hC, 3'd2, 3'd0, 8'd5);
    mem[2] = enc(4'h3, 3'd3, 3'd1, 8'd2);
    mem[3] = enc(4'hF, 3'd0, 3'd0, 8'd0);
    start_prog(3, 1'b1);
    run_to_halt("B", 80);
    check("B_r3", int'(dut.rf_q[3]), 8'hFE);
    check("B_flags", int'(flags), 3'b101);
    check_gaps("B", 4, 7);

    // C: SUB 5-5
    clear_mem();
    mem[0] = enc(4'hC, 3'd1, 3'd0, 8'd5);
    mem[1] = enc(4'h3, 3'd3, 3'd1, 8'd1);
    mem[2] = enc(4'hF, 3'd0, 3'd0, 8'd0);
    start_prog(-1, 1'b1);
    run_to_halt("C", 60);
    check("C_r3", int'(dut.rf_q[3]), 0);
    check("C_flags", int'(flags), 3'b010);

    // D: SHRI by 8 gives zero (JZ taken), SHRI by 1 gives 0x7F
    clear_mem();
    mem[0]  = enc(4'hC, 3'd1, 3'd0, 8'hFF);
    mem[1]  = enc(4'h6, 3'd2, 3'd1, 8'd8);
    mem[2]  = enc(4'h9, 3'd0, 3'd0, 8'h20);
    mem[3]  = enc(4'hC, 3'd4, 3'd0, 8'h55);
    mem[4]  = enc(4'hF, 3'd0, 3'd0, 8'd0);
    mem[32] = enc(4'h6, 3'd3, 3'd1, 8'd1);
    mem[33] = enc(4'hF, 3'd0, 3'd0, 8'd0);
    start_prog(-1, 1'b1);
    run_to_halt("D", 100);
    check("D_r2", int'(dut.rf_q[2]), 0);
    check("D_r3", int'(dut.rf_q[3]), 8'h7F);
    check("D_r4", int'(dut.rf_q[4]), 0);
    check("D_flags", int'(flags), 0);

    // E: JZ taken after zero result, not taken after nonzero result
    clear_mem();
    mem[0]   = enc(4'hC, 3'd1, 3'd0, 8'd5);
    mem[1]   = enc(4'h3, 3'd2, 3'd1, 8'd1);
    mem[2]   = enc(4'h9, 3'd0, 3'd0, 8'h40);
    mem[3]   = enc(4'hF, 3'd0, 3'd0, 8'd0);
    mem[64]  = enc(4'h4, 3'd3, 3'd1, 8'd1);
    mem[65]  = enc(4'h9, 3'd0, 3'd0, 8'h80);
    mem[66]  = enc(4'hC, 3'd5, 3'd0, 8'h33);
    mem[67]  = enc(4'hF, 3'd0, 3'd0, 8'd0);
    mem[128] = enc(4'hC, 3'd4, 3'd0, 8'hAA);
    mem[129] = enc(4'hF, 3'd0, 3'd0, 8'd0);
    start_prog(-1, 1'b1);
    run_to_halt("E", 120);
    check("E_r3", int'(dut.rf_q[3]), 6);
    check("E_r5", int'(dut.rf_q[5]), 8'h33);
    check("E_r4", int'(dut.rf_q[4]), 0);

    // F: NOP at 0xFF wraps pc to 0x00; loop exits on the second pass
    clear_mem();
    mem[0]   = enc(4'h4, 3'd1, 3'd1, 8'd1);
    mem[1]   = enc(4'h7, 3'd2, 3'd1, 8'd2);
    mem[2]   = enc(4'h9, 3'd0, 3'd0, 8'h10);
    mem[3]   = enc(4'h8, 3'd0, 3'd0, 8'hFF);
    mem[16]  = enc(4'hF, 3'd0, 3'd0, 8'd0);
    start_prog(-1, 1'b1);
    run_to_halt("F", 200);
    check("F_r1", int'(dut.rf_q[1]), 2);
    check("F_r2", int'(dut.rf_q[2]), 0);
    check("F_flags", int'(flags), 3'b010);
    check("F_model_r1", int'(m_regs[1]), 2);

    // Randomized programs, ack delays, spurious acks and occasional resets
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 256; i++) begin
        w = 18'($urandom);
        if (w[17:14] == 4'hF && $urandom_range(0, 3) != 0) w[17:14] = 4'hD;
        mem[i] = w;
      end
      start_prog(-1, 1'b1);
      for (int n = 0; n < 600; n++) tick($urandom_range(0, 149) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
